z88_sram_arbiter: RTL and testbench

Two-port arbiter and sequencer for the DE1 board's 256K×16 asynchronous SRAM, which holds the Z88's 512 KB byte-addressed internal RAM. It sits between the top level and the SRAM pins. Port 0 serves the Z88 core's RAM bus. Port 1 serves a second byte-wide master, such as the screen fetch or a loader DMA. The block serializes accesses, drives the byte-lane strobes and registers read data; the top level only performs the tristate on the data pins.

---
 rtl/z88_sram_arbiter_if.sv | 51 +++++
 rtl/z88_sram_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_z88_sram_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/z88_sram_arbiter_if.sv
// Bus bundle between the two byte-wide masters, the arbiter and the SRAM pins.
// The slave modport is the arbiter's view; the master modport is the
// requesters' and pin-driver's view.
interface z88_sram_arbiter_if;
  // Port 0: Z88 core RAM bus
  logic        p0_req;
  logic        p0_we;
  logic [18:0] p0_a;
  logic [7:0]  p0_di;
  logic [7:0]  p0_do;
  logic        p0_ack;
  // Port 1: secondary master (screen fetch, loader DMA)
  logic        p1_req;
  logic        p1_we;
  logic [18:0] p1_a;
  logic [7:0]  p1_di;
  logic [7:0]  p1_do;
  logic        p1_ack;
  // SRAM pins (tristate is resolved at the top level)
  logic [17:0] sram_a;
  logic [15:0] sram_dq_i;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  modport slave (
    input  p0_req, p0_we, p0_a, p0_di,
    output p0_do, p0_ack,
    input  p1_req, p1_we, p1_a, p1_di,
    output p1_do, p1_ack,
    output sram_a,
    input  sram_dq_i,
    output sram_dq_o, sram_dq_oe,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );

  modport master (
    output p0_req, p0_we, p0_a, p0_di,
    input  p0_do, p0_ack,
    output p1_req, p1_we, p1_a, p1_di,
    input  p1_do, p1_ack,
    input  sram_a,
    output sram_dq_i,
    input  sram_dq_o, sram_dq_oe,
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );
endinterface

// File: rtl/z88_sram_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 256Kx16 async
// SRAM holding the Z88's byte-addressed RAM. Every output is registered.
module z88_sram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input logic                  clk,
  input logic                  reset_n,
  z88_sram_arbiter_if.slave    bus
);

  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access_cycles
    $error("ACCESS_CYCLES must be in 1..15");
  end

  localparam logic [3:0] CntLoad = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  state_e r_state, w_state_d;

  logic [3:0]  r_cnt, w_cnt_d;
  logic        r_sel, w_sel_d;                 // port owning the current access
  logic        r_last_grant, w_last_grant_d;   // 0 = port 0, 1 = port 1
  logic        r_we, w_we_d;
  logic        r_lane, w_lane_d;               // byte address bit 0 (1 = upper byte)
  logic [17:0] r_sram_a, w_sram_a_d;
  logic [15:0] r_dq_o, w_dq_o_d;
  logic        r_dq_oe, w_dq_oe_d;
  logic        r_ce_n, w_ce_n_d;
  logic        r_oe_n, w_oe_n_d;
  logic        r_we_n, w_we_n_d;
  logic        r_ub_n, w_ub_n_d;
  logic        r_lb_n, w_lb_n_d;
  logic [7:0]  r_p0_do, w_p0_do_d;
  logic [7:0]  r_p1_do, w_p1_do_d;
  logic        r_p0_ack, w_p0_ack_d;
  logic        r_p1_ack, w_p1_ack_d;

  logic        w_any_req;
  logic        w_grant;
  logic        w_sel_we;
  logic [18:0] w_sel_a;
  logic [7:0]  w_sel_di;
  logic [7:0]  w_rd_byte;

  assign w_any_req = bus.p0_req | bus.p1_req;
  assign w_rd_byte = r_lane ? bus.sram_dq_i[15:8] : bus.sram_dq_i[7:0];

  // Grant: a lone requester wins; on a tie the port not granted last wins.
  always_comb begin
    w_grant = bus.p1_req;
    if (bus.p0_req && bus.p1_req) begin
      w_grant = ~r_last_grant;
    end
    w_sel_we = w_grant ? bus.p1_we : bus.p0_we;
    w_sel_a  = w_grant ? bus.p1_a  : bus.p0_a;
    w_sel_di = w_grant ? bus.p1_di : bus.p0_di;
  end

  // Next-state and registered-output values; strobes idle high unless driven.
  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_sel_d        = r_sel;
    w_last_grant_d = r_last_grant;
    w_we_d         = r_we;
    w_lane_d       = r_lane;
    w_sram_a_d     = r_sram_a;
    w_dq_o_d       = r_dq_o;
    w_dq_oe_d      = r_dq_oe;
    w_ce_n_d       = 1'b1;
    w_oe_n_d       = 1'b1;
    w_we_n_d       = 1'b1;
    w_ub_n_d       = 1'b1;
    w_lb_n_d       = 1'b1;
    w_p0_ack_d     = 1'b0;
    w_p1_ack_d     = 1'b0;
    w_p0_do_d      = r_p0_do;
    w_p1_do_d      = r_p1_do;

    unique case (r_state)
      StIdle: begin
        w_dq_oe_d = 1'b0;
        if (w_any_req) begin
          w_state_d      = StAccess;
          w_sel_d        = w_grant;
          w_last_grant_d = w_grant;
          w_we_d         = w_sel_we;
          w_lane_d       = w_sel_a[0];
          w_sram_a_d     = w_sel_a[18:1];
          w_dq_o_d       = {w_sel_di, w_sel_di};
          w_cnt_d        = CntLoad;
          w_ce_n_d       = 1'b0;
          w_oe_n_d       = w_sel_we;
          w_we_n_d       = ~w_sel_we;
          w_ub_n_d       = ~w_sel_a[0];
          w_lb_n_d       = w_sel_a[0];
          w_dq_oe_d      = w_sel_we;
        end
      end

      StAccess: begin
        if (r_cnt == 4'd0) begin
          // Strobes release here; dq_oe is left alone so write data outlives we_n.
          w_state_d = StDone;
          if (r_sel) begin
            w_p1_ack_d = 1'b1;
            if (!r_we) begin
              w_p1_do_d = w_rd_byte;
            end
          end else begin
            w_p0_ack_d = 1'b1;
            if (!r_we) begin
              w_p0_do_d = w_rd_byte;
            end
          end
        end else begin
          w_cnt_d  = r_cnt - 4'd1;
          w_ce_n_d = 1'b0;
          w_oe_n_d = r_we;
          w_we_n_d = ~r_we;
          w_ub_n_d = ~r_lane;
          w_lb_n_d = r_lane;
        end
      end

      StDone: begin
        w_state_d = StIdle;
        w_dq_oe_d = 1'b0;
      end

      default: begin
        w_state_d = StIdle;
        w_dq_oe_d = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Datapath and pin registers; reset aborts any access with strobes high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= 4'd0;
      r_sel        <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_lane       <= 1'b0;
      r_sram_a     <= 18'd0;
      r_dq_o       <= 16'd0;
      r_dq_oe      <= 1'b0;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_ub_n       <= 1'b1;
      r_lb_n       <= 1'b1;
      r_p0_do      <= 8'd0;
      r_p1_do      <= 8'd0;
      r_p0_ack     <= 1'b0;
      r_p1_ack     <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_d;
      r_sel        <= w_sel_d;
      r_last_grant <= w_last_grant_d;
      r_we         <= w_we_d;
      r_lane       <= w_lane_d;
      r_sram_a     <= w_sram_a_d;
      r_dq_o       <= w_dq_o_d;
      r_dq_oe      <= w_dq_oe_d;
      r_ce_n       <= w_ce_n_d;
      r_oe_n       <= w_oe_n_d;
      r_we_n       <= w_we_n_d;
      r_ub_n       <= w_ub_n_d;
      r_lb_n       <= w_lb_n_d;
      r_p0_do      <= w_p0_do_d;
      r_p1_do      <= w_p1_do_d;
      r_p0_ack     <= w_p0_ack_d;
      r_p1_ack     <= w_p1_ack_d;
    end
  end

  assign bus.p0_do      = r_p0_do;
  assign bus.p1_do      = r_p1_do;
  assign bus.p0_ack     = r_p0_ack;
  assign bus.p1_ack     = r_p1_ack;
  assign bus.sram_a     = r_sram_a;
  assign bus.sram_dq_o  = r_dq_o;
  assign bus.sram_dq_oe = r_dq_oe;
  assign bus.sram_ce_n  = r_ce_n;
  assign bus.sram_oe_n  = r_oe_n;
  assign bus.sram_we_n  = r_we_n;
  assign bus.sram_ub_n  = r_ub_n;
  assign bus.sram_lb_n  = r_lb_n;

endmodule

// File: tb/tb_z88_sram_arbiter.sv
// Directed bench for z88_sram_arbiter: SRAM behavioural model, ack scoreboard,
// plus two extra instances for the ACCESS_CYCLES extremes.
module tb_z88_sram_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  z88_sram_arbiter_if bus ();
  z88_sram_arbiter_if bus1 ();
  z88_sram_arbiter_if bus15 ();

  z88_sram_arbiter #(.ACCESS_CYCLES(2)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  z88_sram_arbiter #(.ACCESS_CYCLES(1)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  z88_sram_arbiter #(.ACCESS_CYCLES(15)) u_dut15 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus15)
  );

  // SRAM model for the main instance; preload port shares the write process.
  logic [15:0] mem [0:262143];
  logic        pl_en = 1'b0;
  logic [17:0] pl_a  = '0;
  logic [15:0] pl_d  = '0;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_a] <= pl_d;
    end else if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe) begin
      if (!bus.sram_lb_n) mem[bus.sram_a][7:0]  <= bus.sram_dq_o[7:0];
      if (!bus.sram_ub_n) mem[bus.sram_a][15:8] <= bus.sram_dq_o[15:8];
    end
  end

  assign bus.sram_dq_i   = bus.sram_oe_n ? 16'hDEAD : mem[bus.sram_a];
  assign bus1.sram_dq_i  = 16'h1234;
  assign bus15.sram_dq_i = 16'h1234;

  typedef struct {
    int         port;
    bit         rd;
    logic [7:0] data;
    int         cyc;
  } sb_item_t;

  sb_item_t sb[$];
  sb_item_t mon_it;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [17:0] a, input logic [15:0] d);
    pl_a  = a;
    pl_d  = d;
    pl_en = 1'b1;
    tick();
    pl_en = 1'b0;
  endtask

  // Drive a request from the IDLE cycle; ack is expected visible 3 edges later.
  task automatic issue(input int port, input bit we, input logic [18:0] a,
                       input logic [7:0] di, input logic [7:0] exp_do);
    sb_item_t it;
    if (port == 0) begin
      bus.p0_we = we; bus.p0_a = a; bus.p0_di = di; bus.p0_req = 1'b1;
    end else begin
      bus.p1_we = we; bus.p1_a = a; bus.p1_di = di; bus.p1_req = 1'b1;
    end
    it.port = port;
    it.rd   = !we;
    it.data = exp_do;
    it.cyc  = cyc + 3;
    sb.push_back(it);
  endtask

  task automatic wait_ack(input int port, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((port == 0) ? bus.p0_ack : bus.p1_ack) begin
        seen = 1'b1;
        if (port == 0) bus.p0_req = 1'b0;
        else bus.p1_req = 1'b0;
        break;
      end
    end
    check($sformatf("ack_seen_p%0d", port), 32'(seen), 32'd1);
    tick();
    check($sformatf("ack_single_p%0d", port), {30'd0, bus.p1_ack, bus.p0_ack}, 32'd0);
  endtask

  // Ack monitor: pop the scoreboard and compare port, timing and read data.
  always @(negedge clk) begin
    if (reset_n && (bus.p0_ack || bus.p1_ack)) begin
      check("ack_exclusive", 32'(bus.p0_ack & bus.p1_ack), 32'd0);
      check("ack_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_it = sb.pop_front();
        check("ack_port", 32'(bus.p1_ack), 32'(mon_it.port));
        check("ack_cycle", 32'(cyc), 32'(mon_it.cyc));
        if (mon_it.rd) begin
          check("read_data", 32'(bus.p1_ack ? bus.p1_do : bus.p0_do), 32'(mon_it.data));
        end
      end
    end
  end

  initial begin
    int k;
    int we_low;
    int acks;
    int w1, w15, a1, a15;
    bit dq_oe_after_rise;

    bus.p0_req = 0; bus.p0_we = 0; bus.p0_a = '0; bus.p0_di = '0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_a = '0; bus.p1_di = '0;
    bus1.p0_req = 0; bus1.p0_we = 0; bus1.p0_a = '0; bus1.p0_di = '0;
    bus1.p1_req = 0; bus1.p1_we = 0; bus1.p1_a = '0; bus1.p1_di = '0;
    bus15.p0_req = 0; bus15.p0_we = 0; bus15.p0_a = '0; bus15.p0_di = '0;
    bus15.p1_req = 0; bus15.p1_we = 0; bus15.p1_a = '0; bus15.p1_di = '0;

    // Reset state
    tick(); tick();
    check("rst_strobes", {27'd0, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n,
                          bus.sram_ub_n, bus.sram_lb_n}, 32'h1F);
    check("rst_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
    check("rst_acks", {30'd0, bus.p1_ack, bus.p0_ack}, 32'd0);
    check("rst_p0_do", 32'(bus.p0_do), 32'd0);
    check("rst_p1_do", 32'(bus.p1_do), 32'd0);
    check("rst_sram_a", 32'(bus.sram_a), 32'd0);
    check("rst_dq_o", 32'(bus.sram_dq_o), 32'd0);
    reset_n = 1'b1;
    tick();
    check("idle_ce_n", 32'(bus.sram_ce_n), 32'd1);

    preload(18'h00000, 16'hA55A);
    preload(18'h00001, 16'hC300);
    preload(18'h3FFFF, 16'h7711);
    tick();

    // Port 0 read of the upper byte
    issue(0, 1'b0, 19'h00001, 8'h00, 8'hA5);
    tick();
    check("p0rd_lanes", {30'd0, bus.sram_ub_n, bus.sram_lb_n}, 32'b01);
    check("p0rd_oe_we", {30'd0, bus.sram_oe_n, bus.sram_we_n}, 32'b01);
    check("p0rd_ce_n", 32'(bus.sram_ce_n), 32'd0);
    check("p0rd_sram_a", 32'(bus.sram_a), 32'd0);
    check("p0rd_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
    wait_ack(0, 10);

    // Port 1 read so p1_do has something a write must not disturb
    issue(1, 1'b0, 19'h7FFFF, 8'h00, 8'h77);
    wait_ack(1, 10);

    // Port 1 write to the lower byte of the top word
    bus.p1_we = 1'b1; bus.p1_a = 19'h7FFFE; bus.p1_di = 8'h3C; bus.p1_req = 1'b1;
    k = cyc;
    begin
      sb_item_t it;
      it.port = 1; it.rd = 1'b0; it.data = 8'h00; it.cyc = k + 3;
      sb.push_back(it);
    end
    tick();
    check("p1wr_sram_a", 32'(bus.sram_a), 32'h3FFFF);
    check("p1wr_lanes", {30'd0, bus.sram_ub_n, bus.sram_lb_n}, 32'b10);
    check("p1wr_dq_o", 32'(bus.sram_dq_o), 32'h3C3C);
    check("p1wr_dq_oe", 32'(bus.sram_dq_oe), 32'd1);
    check("p1wr_oe_n", 32'(bus.sram_oe_n), 32'd1);
    we_low = bus.sram_we_n ? 0 : 1;
    tick();
    we_low += bus.sram_we_n ? 0 : 1;
    tick();
    we_low += bus.sram_we_n ? 0 : 1;
    dq_oe_after_rise = bus.sram_dq_oe;
    bus.p1_req = 1'b0;
    tick();
    check("p1wr_we_width", 32'(we_low), 32'd2);
    check("p1wr_dq_oe_hold", 32'(dq_oe_after_rise), 32'd1);
    check("p1wr_dq_oe_off", 32'(bus.sram_dq_oe), 32'd0);
    check("p1wr_do_kept", 32'(bus.p1_do), 32'h77);
    check("sram_a_held", 32'(bus.sram_a), 32'h3FFFF);

    // Read back both bytes of the written word
    issue(0, 1'b0, 19'h7FFFE, 8'h00, 8'h3C);
    wait_ack(0, 10);
    issue(1, 1'b0, 19'h7FFFF, 8'h00, 8'h77);
    wait_ack(1, 10);

    // Both ports requesting continuously: expect 0,1,0,1 at 4-cycle spacing
    bus.p0_we = 1'b0; bus.p0_a = 19'h00000; bus.p0_req = 1'b1;
    bus.p1_we = 1'b0; bus.p1_a = 19'h00003; bus.p1_req = 1'b1;
    k = cyc;
    for (int i = 0; i < 4; i++) begin
      sb_item_t it;
      it.port = i % 2;
      it.rd   = 1'b1;
      it.data = (i % 2 == 0) ? 8'h5A : 8'hC3;
      it.cyc  = k + 3 + 4 * i;
      sb.push_back(it);
    end
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.p0_ack || bus.p1_ack) acks++;
      if (acks == 4) begin
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        break;
      end
    end
    check("rr_ack_count", 32'(acks), 32'd4);
    tick();

    // Reset during the ACCESS phase of a write
    bus.p0_we = 1'b1; bus.p0_a = 19'h00010; bus.p0_di = 8'h55; bus.p0_req = 1'b1;
    tick();
    check("mid_we_low", 32'(bus.sram_we_n), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_we_n", 32'(bus.sram_we_n), 32'd1);
    check("mid_ce_n", 32'(bus.sram_ce_n), 32'd1);
    check("mid_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
    check("mid_do", {16'd0, bus.p1_do, bus.p0_do}, 32'd0);
    check("mid_sram_a", 32'(bus.sram_a), 32'd0);
    bus.p0_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_no_ack", {30'd0, bus.p1_ack, bus.p0_ack}, 32'd0);
    end
    reset_n = 1'b1;
    tick();
    issue(0, 1'b1, 19'h00010, 8'h55, 8'h00);
    wait_ack(0, 10);
    issue(1, 1'b0, 19'h00010, 8'h00, 8'h55);
    wait_ack(1, 10);

    // ACCESS_CYCLES extremes: strobe width and ack position
    bus1.p0_a = 19'h00000; bus1.p0_req = 1'b1;
    bus15.p0_a = 19'h00000; bus15.p0_req = 1'b1;
    k = cyc;
    w1 = 0; w15 = 0; a1 = -1; a15 = -1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (!bus1.sram_ce_n) w1++;
      if (!bus15.sram_ce_n) w15++;
      if (bus1.p0_ack && a1 < 0) begin
        a1 = cyc;
        check("ac1_do", 32'(bus1.p0_do), 32'h34);
        bus1.p0_req = 1'b0;
      end
      if (bus15.p0_ack && a15 < 0) begin
        a15 = cyc;
        check("ac15_do", 32'(bus15.p0_do), 32'h34);
        bus15.p0_req = 1'b0;
      end
    end
    check("ac1_width", 32'(w1), 32'd1);
    check("ac15_width", 32'(w15), 32'd15);
    check("ac1_ack_cycle", 32'(a1), 32'(k + 2));
    check("ac15_ack_cycle", 32'(a15), 32'(k + 16));

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
